// File: rtl/seq_serial_pkg.sv
// Shared types and default sync preamble for the serial transmitter and the
// sequence-detector side of the serial line.
package seq_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    PAR
  } state_e;

  localparam int unsigned    SYNC_LEN_DEFAULT     = 3;
  localparam logic [2:0]     SYNC_PATTERN_DEFAULT = 3'b101;

endpackage

// File: rtl/seq_tx_shifter.sv
// Loadable MSB-first shift register; load has priority over shift, zero fill.
module seq_tx_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= data;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/seq_serial_tx.sv
// Serial frame transmitter: sync preamble then data word MSB-first.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the data.
module seq_serial_tx
  import seq_serial_pkg::*;
#(
  parameter int unsigned          WIDTH        = 8,
  parameter int unsigned          SYNC_LEN     = SYNC_LEN_DEFAULT,
  parameter logic [SYNC_LEN-1:0]  SYNC_PATTERN = SYNC_PATTERN_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW  = $clog2(WIDTH > SYNC_LEN ? WIDTH : SYNC_LEN);
  localparam int unsigned SyncW = 1 << CntW;
  // Pattern widened so the counter can index it directly.
  localparam logic [SyncW-1:0] SyncExt = SyncW'(SYNC_PATTERN);

  state_e          state;
  logic [CntW-1:0] cnt;
  logic            msb;
  logic            load;
  logic            shift;
`ifdef SEQ_TX_PARITY_EN
  logic            parity;
`endif

  assign in_ready = (state == IDLE);
  assign load     = in_ready & in_valid;
  // Each data bit is shifted out as it is copied into the registered out.
  assign shift    = ((state == SYNC) && (cnt == '0)) || ((state == DATA) && (cnt != '0));

  seq_tx_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .shift(shift),
    .data (in_data),
    .msb  (msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          if (in_valid) begin
            state     <= SYNC;
            cnt       <= CntW'(SYNC_LEN - 1);
            out       <= SYNC_PATTERN[SYNC_LEN-1];
            out_valid <= 1'b1;
            busy      <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
            parity    <= ^in_data;
`endif
          end
        end
        SYNC: begin
          if (cnt == '0) begin
            state <= DATA;
            cnt   <= CntW'(WIDTH - 1);
            out   <= msb;
          end else begin
            cnt <= cnt - 1'b1;
            out <= SyncExt[cnt-1'b1];
          end
        end
        DATA: begin
          if (cnt == '0) begin
`ifdef SEQ_TX_PARITY_EN
            state <= PAR;
            out   <= parity;
`else
            state     <= IDLE;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
            out <= msb;
          end
        end
        PAR: begin
          state     <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_serial_tx.sv
// Directed bench for seq_serial_tx with a bit-level scoreboard of expected frame bits.
module tb_seq_serial_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam int FrameLen = 12;
`else
  localparam int FrameLen = 11;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int done_seen_cnt = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  seq_serial_tx #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    logic [2:0] sync;
    sync = 3'b101;
    for (int i = 2; i >= 0; i--) exp_q.push_back(sync[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SEQ_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  // One clock: sample at the falling edge and score any frame bit.
  task automatic cycle();
    bit b;
    @(negedge clk);
    if (done === 1'b1) done_seen_cnt++;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bit", out_valid, 0);
      end else begin
        b = exp_q.pop_front();
        check("out_bit", out, b);
        check("busy_in_frame", busy, 1);
      end
    end
  endtask

  task automatic run_frame(input int exp_len, input bit hold, output int done_at);
    int n;
    n = 0;
    done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (i == 1 && !hold) in_valid = 1'b0;
      if (out_valid === 1'b1) n++;
      if (done === 1'b1) begin
        done_at = i;
        break;
      end
    end
    check("done_cycle", done_at, exp_len + 1);
    check("frame_bits", n, exp_len);
    check("sb_drained", exp_q.size(), 0);
    if (done_at != 0) begin
      check("done_valid_low", out_valid, 0);
      check("done_ready_high", in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d_at;
    int cnt;

    // Reset held two cycles with a valid word presented.
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      check("rst_out", out, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    check("no_accept_in_reset", out_valid, 0);

    // Single frames.
    in_valid = 1'b1;
    in_data = 8'hA5;
    push_frame(8'hA5);
    run_frame(FrameLen, 1'b0, d_at);
    cycle();
    check("done_one_cycle", done, 0);

    in_valid = 1'b1;
    in_data = 8'h07;
    push_frame(8'h07);
    run_frame(FrameLen, 1'b0, d_at);
    cycle();

    // Back-to-back: in_valid held, next word presented on the done cycle.
    in_valid = 1'b1;
    in_data = 8'hFF;
    push_frame(8'hFF);
    run_frame(FrameLen, 1'b1, d_at);
    in_data = 8'h00;
    push_frame(8'h00);
    run_frame(FrameLen, 1'b0, d_at);
    cycle();

    // in_valid pulsed during the 4th bit of an active frame.
    in_valid = 1'b1;
    in_data = 8'hA5;
    push_frame(8'hA5);
    cnt = 0;
    d_at = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      in_valid = (i == 4);
      if (i == 4) begin
        check("ready_low_busy", in_ready, 0);
        in_data = 8'h3C;
      end
      if (out_valid === 1'b1) cnt++;
      if (done === 1'b1) begin
        d_at = i;
        break;
      end
    end
    in_valid = 1'b0;
    check("inject_done_cycle", d_at, FrameLen + 1);
    check("inject_frame_bits", cnt, FrameLen);
    cnt = 0;
    repeat (15) begin
      cycle();
      if (out_valid === 1'b1) cnt++;
    end
    check("no_second_frame", cnt, 0);
    check("inject_sb_drained", exp_q.size(), 0);

    // Reset during the 5th data bit, then a clean frame.
    done_seen_cnt = 0;
    in_valid = 1'b1;
    in_data = 8'hC3;
    push_frame(8'hC3);
    for (int i = 1; i <= 8; i++) begin
      cycle();
      in_valid = 1'b0;
    end
    check("pre_abort_valid", out_valid, 1);
    reset = 1'b1;
    cycle();
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", out, 0);
    reset = 1'b0;
    exp_q.delete();
    repeat (5) cycle();
    check("abort_no_done", done_seen_cnt, 0);
    in_valid = 1'b1;
    in_data = 8'h5A;
    push_frame(8'h5A);
    run_frame(FrameLen, 1'b0, d_at);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_serial_tx.md
Name: seq_serial_tx

Overview:
Serial pattern transmitter; the sending end of the single-bit serial line consumed by the team's sequence-detector FSMs.
- Accepts one parallel word per frame through a valid/ready handshake.
- Emits a fixed sync preamble, then the word MSB-first, one bit per clk cycle on out.
- Used as an on-chip stimulus source and loopback driver for the detector blocks.

Parameters:
WIDTH, 8, data word width in bits (>=2)
SYNC_LEN, 3, preamble length in bits (1..8)
SYNC_PATTERN, 3'b101, preamble bits, sent MSB (bit SYNC_LEN-1) first

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  word to transmit
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
out  output  1  serial bit
out_valid  output  1  out carries a frame bit this cycle
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last frame bit

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (reset), sampled on the clk rising edge only.
- Registered outputs: all outputs except in_ready are registered. in_ready is the decode `state==IDLE`.
- Reset values: out=0, out_valid=0, busy=0, done=0, state=IDLE, shift register=0, bit counter=0. in_ready is 1 once reset is low.
- States: IDLE, SYNC, DATA, and PAR (PAR exists only with the macro).
- IDLE:
  - out=0, out_valid=0, busy=0.
  - When in_valid && in_ready at edge N: latch in_data into the shift register, load counter=SYNC_LEN-1, go to SYNC.
  - in_data is sampled only at acceptance; later changes have no effect.
- SYNC:
  - Cycle k (k=0..SYNC_LEN-1) after acceptance drives out=SYNC_PATTERN[SYNC_LEN-1-k], with out_valid=1, busy=1.
  - When the counter reaches 0: load counter=WIDTH-1, go to DATA.
- DATA:
  - Drives out=shreg[WIDTH-1], out_valid=1, then shifts left by 1 (zero fill).
  - When the counter reaches 0: go to PAR if enabled, else IDLE.
- Frame end: on entering IDLE, done=1 for exactly one cycle. out_valid=0 in that cycle and in_ready=1 in the same cycle.
- Latency:
  - First frame bit is visible in cycle N+1.
  - Last data bit is in cycle N+SYNC_LEN+WIDTH.
  - done is in cycle N+SYNC_LEN+WIDTH+1 (+1 with parity).
- Back-to-back frames: minimum gap is exactly one idle cycle (out_valid=0). A word accepted in the done cycle starts its sync bit on the next cycle.
- in_valid while busy: in_ready=0, so the word is not accepted. Upstream must hold it; nothing is latched or lost internally.
- Reset mid-frame: at the next edge all outputs return to reset values and state=IDLE. No done pulse is produced and the partial frame is abandoned.
- Simultaneous reset and in_valid: reset wins; nothing is accepted.
- Counter width: $clog2(max(WIDTH,SYNC_LEN)). The counter never wraps; it is reloaded on every state entry.

Optional Feature:
SEQ_TX_PARITY_EN
- Defined: after DATA, the PAR state drives one bit out = XOR of the latched in_data (even parity), with out_valid=1. The frame is SYNC_LEN+WIDTH+1 bits. The parity bit is computed from the latched copy, not the live in_data.
- Undefined: there is no PAR state, and DATA goes directly to IDLE. Frame length is SYNC_LEN+WIDTH.

Decomposition:
- Package seq_serial_pkg holds:
  - state enum (IDLE, SYNC, DATA, PAR)
  - default SYNC_PATTERN / SYNC_LEN constants, shared with the sequence-detector side
- One natural sub-module: seq_tx_shifter, a loadable WIDTH-bit MSB-first shift register with load/shift enables and a serial msb output.
- FSM, counter and parity stay in seq_serial_tx.

Test Plan:
1. Reset held 2 cycles with in_valid=1, in_data=8'hFF:
   - out=0, out_valid=0, busy=0, done=0, no acceptance.
   - in_ready=1 on the first cycle after release.
2. Single frame, in_data=8'hA5, no macro:
   - out = 1,0,1,1,0,1,0,0,1,0,1 over 11 consecutive cycles with out_valid=1.
   - done=1 on cycle 12 only.
3. With SEQ_TX_PARITY_EN:
   - 8'hA5 gives 12-bit frame ending in parity 0.
   - 8'h07 gives frame ending in parity 1.
   - done on cycle 13.
4. in_valid held high with 8'hFF, then 8'h00 presented on the done cycle:
   - Second frame's first sync bit (1) appears one cycle after done.
   - Exactly one out_valid=0 gap between frames.
5. in_data=8'h3C with in_valid pulsed during the 4th bit of an active frame:
   - in_ready=0, word not accepted.
   - Current frame unchanged, no second frame sent.
6. reset asserted for one cycle during the 5th data bit:
   - Next cycle out_valid=0, busy=0.
   - done never pulses.
   - After release, a new 8'h5A frame transmits correctly: 1,0,1,0,1,0,1,1,0,1,0.
